// File: rtl/hazard_sb.sv
// hazard_sb: hazard detection, forwarding control and mult/div busy tracking
// for the 5-stage pipeline, generalised to NSRC source operands.
// Optional feature macro: HAZARD_PERF_EN (implements stall/load-use/muldiv
// performance counters; otherwise the counter outputs are tied to zero).
module hazard_sb #(
  parameter int REGW     = 5,
  parameter int NSRC     = 2,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 16,
  parameter int STAT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*REGW-1:0]   srcD,
  input  logic [NSRC-1:0]        srcvalidD,
  input  logic [NSRC*REGW-1:0]   srcE,
  input  logic                   branchD,
  input  logic                   hiloreadD,
  input  logic                   muldivD,
  input  logic [REGW-1:0]        writeregE,
  input  logic [REGW-1:0]        writeregM,
  input  logic [REGW-1:0]        writeregW,
  input  logic                   regwriteE,
  input  logic                   regwriteM,
  input  logic                   regwriteW,
  input  logic                   memtoregE,
  input  logic                   memtoregM,
  input  logic                   muldivE,
  input  logic                   divE,
  input  logic                   perfclr,
  output logic [2*NSRC-1:0]      forwardE,
  output logic [NSRC-1:0]        forwardD,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   flushE,
  output logic                   mdbusy,
  output logic [STAT_W-1:0]      stallcnt,
  output logic [STAT_W-1:0]      lwcnt,
  output logic [STAT_W-1:0]      mdcnt
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lwstall_s;
  logic             branchstall_s;
  logic             mdstall_s;
  logic             flush_s;

  // True when any operand actually read in D names non-zero register r.
  function automatic logic match_f(input logic [NSRC*REGW-1:0] src,
                                   input logic [NSRC-1:0]      valid,
                                   input logic [REGW-1:0]      r);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (valid[i] && (src[i*REGW +: REGW] == r) && (r != {REGW{1'b0}})) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Per-operand forwarding selects; the younger M result beats W.
  always_comb begin
    forwardE = {(2*NSRC){1'b0}};
    forwardD = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if ((srcE[i*REGW +: REGW] != {REGW{1'b0}}) && (srcE[i*REGW +: REGW] == writeregM) && regwriteM) begin
        forwardE[2*i +: 2] = 2'b10;
      end else if ((srcE[i*REGW +: REGW] != {REGW{1'b0}}) && (srcE[i*REGW +: REGW] == writeregW) && regwriteW) begin
        forwardE[2*i +: 2] = 2'b01;
      end else begin
        forwardE[2*i +: 2] = 2'b00;
      end
      forwardD[i] = (srcD[i*REGW +: REGW] != {REGW{1'b0}}) && (srcD[i*REGW +: REGW] == writeregM) && regwriteM;
    end
  end

  // Stall sources: load-use, branch-compare-in-D, and mult/div occupancy.
  always_comb begin
    lwstall_s     = memtoregE && match_f(srcD, srcvalidD, writeregE);
    branchstall_s = branchD && ((regwriteE && match_f(srcD, srcvalidD, writeregE)) ||
                                (memtoregM && match_f(srcD, srcvalidD, writeregM)));
    mdstall_s     = (hiloreadD || muldivD) && ((state_q == BUSY) || muldivE);
    flush_s       = lwstall_s || branchstall_s || mdstall_s;
  end

  assign flushE = flush_s;
  assign stallD = flush_s;
  assign stallF = flush_s;
  assign mdbusy = (state_q == BUSY);

  // Mult/div busy tracker: an issue (re)loads the latency from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else if (muldivE) begin
      state_q <= BUSY;
      cnt_q   <= divE ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else begin
      case (state_q)
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
          end else begin
            state_q <= BUSY;
          end
        end
        IDLE: begin
          state_q <= IDLE;
          cnt_q   <= cnt_q;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [STAT_W-1:0] stallcnt_q;
  logic [STAT_W-1:0] lwcnt_q;
  logic [STAT_W-1:0] mdcnt_q;

  // Saturating increment: holds at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc_f(input logic [STAT_W-1:0] v,
                                                  input logic              en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + STAT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Performance counters; a clear request wins over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallcnt_q <= {STAT_W{1'b0}};
      lwcnt_q    <= {STAT_W{1'b0}};
      mdcnt_q    <= {STAT_W{1'b0}};
    end else if (perfclr) begin
      stallcnt_q <= {STAT_W{1'b0}};
      lwcnt_q    <= {STAT_W{1'b0}};
      mdcnt_q    <= {STAT_W{1'b0}};
    end else begin
      stallcnt_q <= sat_inc_f(stallcnt_q, flush_s);
      lwcnt_q    <= sat_inc_f(lwcnt_q, lwstall_s);
      mdcnt_q    <= sat_inc_f(mdcnt_q, mdstall_s);
    end
  end

  assign stallcnt = stallcnt_q;
  assign lwcnt    = lwcnt_q;
  assign mdcnt    = mdcnt_q;
`else
  logic unused_perfclr_s;
  assign unused_perfclr_s = perfclr;
  assign stallcnt = {STAT_W{1'b0}};
  assign lwcnt    = {STAT_W{1'b0}};
  assign mdcnt    = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: expectations are queued as stimulus is
// driven and popped against DUT outputs sampled away from the rising edge.
module tb_hazard_sb;

  localparam int REGW = 5;
  localparam int NSRC = 2;
  localparam int MLAT = 4;
  localparam int DLAT = 16;

  logic clk;
  logic reset;
  logic [NSRC*REGW-1:0] srcD, srcE;
  logic [NSRC-1:0] srcvalidD;
  logic branchD, hiloreadD, muldivD;
  logic [REGW-1:0] writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic muldivE, divE, perfclr;

  logic [2*NSRC-1:0] forwardE;
  logic [NSRC-1:0]   forwardD;
  logic stallF, stallD, flushE, mdbusy;
  logic [31:0] stallcnt, lwcnt, mdcnt;

  logic [2*NSRC-1:0] unused_fwdE;
  logic [NSRC-1:0]   unused_fwdD;
  logic unused_sF, unused_sD, unused_fE, unused_busy;
  logic [2:0] sat_stallcnt, unused_lw3, unused_md3;

  int n_cmp = 0;
  int n_err = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];

  hazard_sb #(.REGW(REGW), .NSRC(NSRC), .MULT_LAT(MLAT), .DIV_LAT(DLAT), .STAT_W(32)) u_dut (
    .clk(clk), .reset(reset), .srcD(srcD), .srcvalidD(srcvalidD), .srcE(srcE),
    .branchD(branchD), .hiloreadD(hiloreadD), .muldivD(muldivD),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .muldivE(muldivE), .divE(divE),
    .perfclr(perfclr), .forwardE(forwardE), .forwardD(forwardD),
    .stallF(stallF), .stallD(stallD), .flushE(flushE), .mdbusy(mdbusy),
    .stallcnt(stallcnt), .lwcnt(lwcnt), .mdcnt(mdcnt)
  );

  hazard_sb #(.REGW(REGW), .NSRC(NSRC), .MULT_LAT(MLAT), .DIV_LAT(DLAT), .STAT_W(3)) u_sat (
    .clk(clk), .reset(reset), .srcD(srcD), .srcvalidD(srcvalidD), .srcE(srcE),
    .branchD(branchD), .hiloreadD(hiloreadD), .muldivD(muldivD),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .muldivE(muldivE), .divE(divE),
    .perfclr(perfclr), .forwardE(unused_fwdE), .forwardD(unused_fwdD),
    .stallF(unused_sF), .stallD(unused_sD), .flushE(unused_fE), .mdbusy(unused_busy),
    .stallcnt(sat_stallcnt), .lwcnt(unused_lw3), .mdcnt(unused_md3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic clear_inputs();
    srcD = '0; srcE = '0; srcvalidD = '0;
    branchD = 1'b0; hiloreadD = 1'b0; muldivD = 1'b0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0;
    muldivE = 1'b0; divE = 1'b0; perfclr = 1'b0;
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] s, input logic [4:0] wm,
                                           input logic [4:0] ww, input logic rm, input logic rw);
    if (s != 5'd0 && s == wm && rm) return 2'b10;
    if (s != 5'd0 && s == ww && rw) return 2'b01;
    return 2'b00;
  endfunction

  // Issue one mult/div with a dependent mfhi held in D and track LAT+2 cycles.
  task automatic run_muldiv(input logic is_div, input int lat);
    @(posedge clk); #1;
    hiloreadD = 1'b1; muldivE = 1'b1; divE = is_div;
    for (int k = 0; k <= lat + 1; k++) begin
      push_exp($sformatf("md%0d_stall_c%0d", is_div, k), {63'd0, (k <= lat)});
      push_exp($sformatf("md%0d_busy_c%0d", is_div, k), {63'd0, (k >= 1 && k <= lat)});
      @(negedge clk);
      pop_chk({63'd0, stallD});
      pop_chk({63'd0, mdbusy});
      @(posedge clk); #1;
      muldivE = 1'b0;
    end
    hiloreadD = 1'b0;
  endtask

  initial begin
    logic [4:0] s0, s1, d0, d1, wm, ww;
    logic rm, rw;

    clear_inputs();
    reset = 1'b0;
    #2;
    push_exp("rst_mdbusy", 64'd0);    pop_chk({63'd0, mdbusy});
    push_exp("rst_flushE", 64'd0);    pop_chk({63'd0, flushE});
    push_exp("rst_forwardE", 64'd0);  pop_chk({60'd0, forwardE});
    push_exp("rst_stallcnt", 64'd0);  pop_chk({32'd0, stallcnt});
    @(negedge clk);
    reset = 1'b1;

    // Forwarding defaults from the plan
    @(posedge clk); #1;
    srcE = {5'd0, 5'd8}; writeregM = 5'd8; writeregW = 5'd8; regwriteM = 1'b1; regwriteW = 1'b1;
    push_exp("fwdE_M", 64'h2); @(negedge clk); pop_chk({62'd0, forwardE[1:0]});
    regwriteM = 1'b0;
    push_exp("fwdE_W", 64'h1); @(negedge clk); pop_chk({62'd0, forwardE[1:0]});
    srcE = {5'd0, 5'd0};
    push_exp("fwdE_r0", 64'h0); @(negedge clk); pop_chk({62'd0, forwardE[1:0]});
    clear_inputs();

    // Randomised forwarding patterns over a small register range
    for (int n = 0; n < 24; n++) begin
      @(posedge clk); #1;
      s0 = 5'($urandom_range(0, 3)); s1 = 5'($urandom_range(0, 3));
      d0 = 5'($urandom_range(0, 3)); d1 = 5'($urandom_range(0, 3));
      wm = 5'($urandom_range(0, 3)); ww = 5'($urandom_range(0, 3));
      rm = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      srcE = {s1, s0}; srcD = {d1, d0}; writeregM = wm; writeregW = ww;
      regwriteM = rm; regwriteW = rw;
      push_exp($sformatf("rnd_fwdE_%0d", n), {60'd0, fwd_model(s1, wm, ww, rm, rw), fwd_model(s0, wm, ww, rm, rw)});
      push_exp($sformatf("rnd_fwdD_%0d", n), {62'd0, (d1 != 5'd0 && d1 == wm && rm), (d0 != 5'd0 && d0 == wm && rm)});
      push_exp($sformatf("rnd_flush_%0d", n), 64'd0);
      @(negedge clk);
      pop_chk({60'd0, forwardE});
      pop_chk({62'd0, forwardD});
      pop_chk({63'd0, flushE});
    end
    clear_inputs();

    // Load-use: only a valid operand creates the hazard
    @(posedge clk); #1;
    memtoregE = 1'b1; writeregE = 5'd9; srcD = {5'd9, 5'd0}; srcvalidD = 2'b10;
    push_exp("lw_flushE", 64'd1); push_exp("lw_stallD", 64'd1); push_exp("lw_stallF", 64'd1);
    @(negedge clk); pop_chk({63'd0, flushE}); pop_chk({63'd0, stallD}); pop_chk({63'd0, stallF});
    srcvalidD = 2'b01;
    push_exp("lw_inv_flushE", 64'd0); push_exp("lw_inv_stallF", 64'd0);
    @(negedge clk); pop_chk({63'd0, flushE}); pop_chk({63'd0, stallF});
    clear_inputs();

    // Branch compare in D
    @(posedge clk); #1;
    branchD = 1'b1; memtoregM = 1'b1; writeregM = 5'd4; srcD = {5'd0, 5'd4}; srcvalidD = 2'b01;
    push_exp("br_memM_stall", 64'd1); @(negedge clk); pop_chk({63'd0, stallD});
    memtoregM = 1'b0; regwriteM = 1'b1;
    push_exp("br_fwd_stall", 64'd0); push_exp("br_fwdD", 64'd1);
    @(negedge clk); pop_chk({63'd0, stallD}); pop_chk({62'd0, forwardD});
    regwriteM = 1'b0; regwriteE = 1'b1; writeregE = 5'd4;
    push_exp("br_aluE_stall", 64'd1); @(negedge clk); pop_chk({63'd0, stallD});
    clear_inputs();

    // Multiply then divide latency windows
    run_muldiv(1'b0, MLAT);
    run_muldiv(1'b1, DLAT);

    // Reset in the middle of a divide
    @(posedge clk); #1;
    hiloreadD = 1'b1; muldivE = 1'b1; divE = 1'b1;
    @(posedge clk); #1;
    muldivE = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    push_exp("mid_div_busy", 64'd1); pop_chk({63'd0, mdbusy});
    #1 reset = 1'b0;
    #1;
    push_exp("rst_div_busy", 64'd0);  pop_chk({63'd0, mdbusy});
    push_exp("rst_div_stall", 64'd0); pop_chk({63'd0, stallD});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_exp("post_rst_busy", 64'd0); pop_chk({63'd0, mdbusy});
    clear_inputs();

    // Performance counters
    @(posedge clk); #1; perfclr = 1'b1;
    @(posedge clk); #1; perfclr = 1'b0;
    memtoregE = 1'b1; writeregE = 5'd9; srcD = {5'd9, 5'd0}; srcvalidD = 2'b10;
    repeat (7) @(posedge clk);
    #1;
`ifdef HAZARD_PERF_EN
    push_exp("perf_lwcnt7", 64'd7);    pop_chk({32'd0, lwcnt});
    push_exp("perf_stall7", 64'd7);    pop_chk({32'd0, stallcnt});
    push_exp("perf_mdcnt0", 64'd0);    pop_chk({32'd0, mdcnt});
    push_exp("perf_sat7", 64'd7);      pop_chk({61'd0, sat_stallcnt});
`endif
    repeat (2) @(posedge clk);
    #1;
    memtoregE = 1'b0;
`ifdef HAZARD_PERF_EN
    push_exp("perf_stall9", 64'd9);    pop_chk({32'd0, stallcnt});
    push_exp("perf_sat_hold", 64'd7);  pop_chk({61'd0, sat_stallcnt});
`else
    push_exp("noperf_stall", 64'd0);   pop_chk({32'd0, stallcnt});
    push_exp("noperf_lw", 64'd0);      pop_chk({32'd0, lwcnt});
    push_exp("noperf_sat", 64'd0);     pop_chk({61'd0, sat_stallcnt});
`endif
    perfclr = 1'b1; memtoregE = 1'b1;
    @(posedge clk); #1;
    perfclr = 1'b0; memtoregE = 1'b0;
    push_exp("perfclr_stall", 64'd0);  pop_chk({32'd0, stallcnt});
    push_exp("perfclr_lw", 64'd0);     pop_chk({32'd0, lwcnt});
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_sb.md
# hazard_sb

Parametrised hazard and scoreboard unit for the 5-stage pipeline. It generalises the stall and forward logic to NSRC source operands per instruction. It adds a registered busy tracker for the multi-cycle multiply/divide unit, with separate configurable multiply and divide latencies, so that HI/LO readers and back-to-back mult/div ops stall precisely. It sits beside the datapath and drives the F/D stall enables, the E flush, and the forwarding muxes in D and E.

## Interface
- REGW, 5, register index width
- NSRC, 2, source operands per instruction (1..4)
- MULT_LAT, 4, multiply latency in cycles (>=1)
- DIV_LAT, 16, divide latency in cycles (>=1)
- STAT_W, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- srcD  in  NSRC*REGW  D-stage source registers; operand i is [i*REGW +: REGW]
- srcvalidD  in  NSRC  operand i actually read in D
- srcE  in  NSRC*REGW  E-stage source registers
- branchD  in  1  D holds a branch that compares in D
- hiloreadD  in  1  D holds mfhi/mflo
- muldivD  in  1  D holds mult/div
- writeregE, writeregM, writeregW  in  REGW each  destination registers
- regwriteE, regwriteM, regwriteW  in  1 each
- memtoregE, memtoregM  in  1 each
- muldivE  in  1  mult/div issues in E this cycle
- divE  in  1  qualifies muldivE: 1 = divide, 0 = multiply
- perfclr  in  1  synchronous clear of the perf counters
- forwardE  out  2*NSRC  per operand: 00 RF, 01 W result, 10 M result
- forwardD  out  NSRC  per operand: 1 = forward M result to the branch comparator
- stallF, stallD, flushE  out  1 each
- mdbusy  out  1  mult/div unit holds an unfinished result
- stallcnt, lwcnt, mdcnt  out  STAT_W each  perf counters

## Operation
- forwardE[i]: 10 if srcE[i]!=0 and srcE[i]==writeregM and regwriteM; else 01 if srcE[i]!=0 and srcE[i]==writeregW and regwriteW; else 00. M has priority over W.
- forwardD[i] = srcD[i]!=0 and srcD[i]==writeregM and regwriteM.
- match(r) = OR over i of (srcvalidD[i] and srcD[i]==r and r!=0).
- lwstall = memtoregE and match(writeregE).
- branchstall = branchD and ((regwriteE and match(writeregE)) or (memtoregM and match(writeregM))).
- mdstall = (hiloreadD or muldivD) and (mdbusy or muldivE).
- flushE = lwstall or branchstall or mdstall; stallD = stallF = flushE.
- Busy tracker, FSM IDLE/BUSY, with counter cnt of width $clog2(max(MULT_LAT,DIV_LAT)+1):
  - On muldivE, cnt <= divE ? DIV_LAT : MULT_LAT and state <= BUSY. This applies in any state, so an issue while BUSY restarts the count.
  - In BUSY without muldivE, cnt decrements. The transition to IDLE occurs on the edge where cnt goes 1->0.
  - mdbusy = (state==BUSY). It is registered.

## Timing
- forwardE, forwardD, stallF, stallD and flushE are combinational, valid in the same cycle as their inputs.
- muldivE in cycle t: mdbusy is high in cycles t+1..t+LAT. A dependent D instruction stalls in cycles t..t+LAT and advances in t+LAT+1.
- Reset (reset=0, asynchronous) gives: state IDLE, cnt 0, mdbusy 0, all perf counters 0. Combinational outputs follow their inputs; with all inputs 0 they are 0.
- Reset asserted during BUSY abandons the operation immediately.
- Perf counters update on the rising edge:
  - stallcnt +1 per cycle with stallD=1.
  - lwcnt +1 per cycle with lwstall=1.
  - mdcnt +1 per cycle with mdstall=1.
  - All counters saturate at all-ones.
  - perfclr has priority over increment.

## Configuration
- HAZARD_PERF_EN defined: the three perf counters are implemented as above.
- HAZARD_PERF_EN undefined: no counter flops exist, stallcnt/lwcnt/mdcnt are tied to 0, perfclr is ignored, and the ports remain present.

## Test plan
- Defaults: srcE[0]=8, writeregM=8, writeregW=8, both regwrite=1 -> forwardE[1:0]=10. With regwriteM=0 -> 01. With srcE[0]=0 -> 00.
- Load-use: memtoregE=1, writeregE=9, srcD[1]=9, srcvalidD=2'b10 -> flushE=stallD=stallF=1. Same setup with srcvalidD=2'b01 -> all 0.
- Branch: branchD=1, memtoregM=1, writeregM=4, srcD[0]=4, valid -> stall 1. With memtoregM=0 and regwriteM=1 -> stall 0 and forwardD[0]=1.
- Multiply: MULT_LAT=4, muldivE=1 at t with hiloreadD held -> stallD high t..t+4, mdbusy high t+1..t+4, stallD low at t+5. A divide gives the same behaviour over 16 cycles.
- Reset mid-divide: assert reset at cycle 5 of BUSY -> mdbusy=0 asynchronously, and stallD drops with hiloreadD still high.
- With HAZARD_PERF_EN: 7 load-use stall cycles -> lwcnt=7, stallcnt=7. perfclr for one cycle -> both 0. STAT_W=3 with 9 stalls -> stallcnt=7 (saturated).
